// File: rtl/sprite_pkg.sv
// Shared definitions for the bouncing-logo motion path.
//   - Screen and sprite geometry, corner-flash duration.
//   - motion_state_e: frame sequencer states.
//   - DIR_POS / DIR_NEG: per-axis direction encoding (1 = towards larger coordinate).
package sprite_pkg;

  localparam int unsigned DISPLAY_WIDTH  = 640;
  localparam int unsigned DISPLAY_HEIGHT = 480;
  localparam int unsigned LOGO_SIZE      = 128;
  localparam int unsigned FLASH_FRAMES   = 16;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    STEP_X     = 2'd1,
    STEP_Y     = 2'd2,
    COMMIT     = 2'd3
  } motion_state_e;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/logo_motion_ctrl_if.sv
// Bundle between the raster timing / control side and the logo motion sequencer.
//   vpos, pause, speed            : control side -> sequencer
//   logo_left, logo_top           : sprite origin for the pixel/ROM datapath
//   color_index                   : palette index
//   bounce, frame_tick            : one-cycle event pulses
//   corner_flash                  : corner highlight (constant 0 unless CORNER_FLASH_EN)
// Modports: master = driver of the controls / consumer of results, slave = sequencer.
interface logo_motion_ctrl_if;

  logic [9:0] vpos;
  logic       pause;
  logic [1:0] speed;
  logic [9:0] logo_left;
  logic [9:0] logo_top;
  logic [2:0] color_index;
  logic       bounce;
  logic       frame_tick;
  logic       corner_flash;

  modport master (
    output vpos, pause, speed,
    input  logo_left, logo_top, color_index, bounce, frame_tick, corner_flash
  );

  modport slave (
    input  vpos, pause, speed,
    output logo_left, logo_top, color_index, bounce, frame_tick, corner_flash
  );

endinterface

// File: rtl/axis_stepper.sv
// Combinational single-axis step with edge reflection.
//   pos      : current origin on this axis
//   dir      : DIR_POS moves towards max_pos, DIR_NEG towards 0
//   step     : pixels to move (1..4)
//   max_pos  : largest legal origin (screen dimension minus sprite size)
//   pos_next : new origin, clamped to [0, max_pos]
//   dir_next : new direction, flipped on an edge hit
//   hit      : edge reached this step
module axis_stepper
  import sprite_pkg::*;
(
  input  logic [9:0] pos,
  input  logic       dir,
  input  logic [2:0] step,
  input  logic [9:0] max_pos,
  output logic [9:0] pos_next,
  output logic       dir_next,
  output logic       hit
);

  // One spare bit so the compare never sees a wrapped sum.
  logic signed [10:0] pos_s;
  logic signed [10:0] step_s;
  logic signed [10:0] max_s;

  assign pos_s  = $signed({1'b0, pos});
  assign step_s = $signed({8'b0, step});
  assign max_s  = $signed({1'b0, max_pos});

  always_comb begin
    pos_next = pos;
    dir_next = dir;
    hit      = 1'b0;
    if (dir == DIR_POS) begin
      if ((pos_s + step_s) >= max_s) begin
        pos_next = max_pos;
        dir_next = DIR_NEG;
        hit      = 1'b1;
      end else begin
        pos_next = pos + {7'b0, step};
      end
    end else begin
      if (pos_s <= step_s) begin
        pos_next = '0;
        dir_next = DIR_POS;
        hit      = 1'b1;
      end else begin
        pos_next = pos - {7'b0, step};
      end
    end
  end

endmodule

// File: rtl/logo_motion_ctrl.sv
// Per-frame motion sequencer for the bouncing-logo sprite.
// Detects the first blanking line from vpos, then steps X and Y through one shared
// axis_stepper and commits both axes at once so the datapath never sees a half move.
// Ports:
//   clk    : pixel clock
//   rst_n  : asynchronous active-low reset
//   bus    : logo_motion_ctrl_if.slave (vpos/pause/speed in; logo_left, logo_top,
//            color_index, bounce, frame_tick, corner_flash out)
// Build option: define CORNER_FLASH_EN to enable the corner_flash frame counter;
// otherwise corner_flash is tied low.
module logo_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned INIT_X    = 200,
  parameter int unsigned INIT_Y    = 200,
  parameter int unsigned V_TRIGGER = 480
) (
  input  logic                clk,
  input  logic                rst_n,
  logo_motion_ctrl_if.slave   bus
);

  localparam logic [9:0] MAX_X  = 10'(DISPLAY_WIDTH - LOGO_SIZE);
  localparam logic [9:0] MAX_Y  = 10'(DISPLAY_HEIGHT - LOGO_SIZE);
  localparam logic [9:0] TRIG_V = 10'(V_TRIGGER);

  motion_state_e state_q;
  logic [9:0]    prev_vpos_q;
  logic          frame_tick_q;
  logic          bounce_q;
  logic [9:0]    left_q, top_q;
  logic          dir_x_q, dir_y_q;
  logic [2:0]    color_q;
  logic [2:0]    step_q;
  logic [9:0]    nx_q, ny_q;
  logic          ndx_q, ndy_q;
  logic          bx_q, by_q;

  logic          tick;
  logic [9:0]    st_pos, st_max, st_pos_next;
  logic          st_dir, st_dir_next, st_hit;
  logic [2:0]    st_step;

  // Rising into the trigger line; reset value of prev_vpos_q suppresses a tick at release.
  assign tick = (bus.vpos == TRIG_V) && (prev_vpos_q != TRIG_V);

  // Stepper operand mux: X in STEP_X (with the live speed), Y otherwise from step_q.
  always_comb begin
    st_pos  = left_q;
    st_dir  = dir_x_q;
    st_step = {1'b0, bus.speed} + 3'd1;
    st_max  = MAX_X;
    if (state_q == STEP_Y) begin
      st_pos  = top_q;
      st_dir  = dir_y_q;
      st_step = step_q;
      st_max  = MAX_Y;
    end
  end

  axis_stepper u_stepper (
    .pos      (st_pos),
    .dir      (st_dir),
    .step     (st_step),
    .max_pos  (st_max),
    .pos_next (st_pos_next),
    .dir_next (st_dir_next),
    .hit      (st_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_FRAME;
      prev_vpos_q  <= TRIG_V;
      frame_tick_q <= 1'b0;
      bounce_q     <= 1'b0;
      left_q       <= 10'(INIT_X);
      top_q        <= 10'(INIT_Y);
      dir_x_q      <= DIR_POS;
      dir_y_q      <= DIR_NEG;
      color_q      <= 3'd0;
      step_q       <= 3'd1;
      nx_q         <= '0;
      ny_q         <= '0;
      ndx_q        <= DIR_POS;
      ndy_q        <= DIR_NEG;
      bx_q         <= 1'b0;
      by_q         <= 1'b0;
    end else begin
      prev_vpos_q  <= bus.vpos;
      frame_tick_q <= tick;
      bounce_q     <= 1'b0;
      unique case (state_q)
        WAIT_FRAME: begin
          if (tick && !bus.pause) begin
            state_q <= STEP_X;
          end
        end
        STEP_X: begin
          step_q  <= st_step;
          nx_q    <= st_pos_next;
          ndx_q   <= st_dir_next;
          bx_q    <= st_hit;
          state_q <= STEP_Y;
        end
        STEP_Y: begin
          ny_q    <= st_pos_next;
          ndy_q   <= st_dir_next;
          by_q    <= st_hit;
          state_q <= COMMIT;
        end
        COMMIT: begin
          left_q  <= nx_q;
          top_q   <= ny_q;
          dir_x_q <= ndx_q;
          dir_y_q <= ndy_q;
          // A corner counts as a single bounce.
          if (bx_q || by_q) begin
            color_q  <= color_q + 3'd1;
            bounce_q <= 1'b1;
          end
          state_q <= WAIT_FRAME;
        end
        default: state_q <= WAIT_FRAME;
      endcase
    end
  end

  assign bus.logo_left   = left_q;
  assign bus.logo_top    = top_q;
  assign bus.color_index = color_q;
  assign bus.bounce      = bounce_q;
  assign bus.frame_tick  = frame_tick_q;

`ifdef CORNER_FLASH_EN
  logic [4:0] flash_cnt_q;

  // Counts frames (paused or not) after the latest corner commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt_q <= 5'd0;
    end else if ((state_q == COMMIT) && bx_q && by_q) begin
      flash_cnt_q <= 5'(FLASH_FRAMES);
    end else if (frame_tick_q && (flash_cnt_q != 5'd0)) begin
      flash_cnt_q <= flash_cnt_q - 5'd1;
    end
  end

  assign bus.corner_flash = (flash_cnt_q != 5'd0);
`else
  assign bus.corner_flash = 1'b0;
`endif

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Bench for logo_motion_ctrl: a main instance at the default start position and a
// second instance started one pixel from the top-right corner to exercise corner hits.
module tb_logo_motion_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logo_motion_ctrl_if bus ();
  logo_motion_ctrl_if bus_c ();

  assign bus_c.vpos  = bus.vpos;
  assign bus_c.pause = bus.pause;
  assign bus_c.speed = bus.speed;

  logo_motion_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logo_motion_ctrl #(
    .INIT_X (511),
    .INIT_Y (1)
  ) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_c)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       pause;
    logic [1:0] speed;
    int         left;
    int         top;
    int         color;
    int         bounces;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic exp_flash(input int ticks_since_corner);
`ifdef CORNER_FLASH_EN
    return ticks_since_corner < 16;
`else
    return (ticks_since_corner < 0);
`endif
  endfunction

  // One frame: vpos sits on the trigger line for one clock, then 8 clocks to settle.
  task automatic run_frame(output int ticks, output int bnc, output int bnc_c);
    ticks = 0;
    bnc   = 0;
    bnc_c = 0;
    @(negedge clk);
    bus.vpos = 10'd480;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) bus.vpos = 10'd0;
      ticks += int'(bus.frame_tick);
      bnc   += int'(bus.bounce);
      bnc_c += int'(bus_c.bounce);
    end
  endtask

  initial begin
    int t, b, bc, tot_b;

    vecs[0] = '{1'b0, 2'd1, 203, 197, 0, 0};
    vecs[1] = '{1'b0, 2'd3, 207, 193, 0, 0};
    vecs[2] = '{1'b0, 2'd2, 210, 190, 0, 0};
    vecs[3] = '{1'b1, 2'd3, 210, 190, 0, 0};
    vecs[4] = '{1'b0, 2'd0, 211, 189, 0, 0};
    vecs[5] = '{1'b0, 2'd3, 215, 185, 0, 0};

    rst_n     = 1'b0;
    bus.vpos  = 10'd0;
    bus.pause = 1'b0;
    bus.speed = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_left", bus.logo_left, 200);
    check("rst_top", bus.logo_top, 200);
    check("rst_color", bus.color_index, 0);
    check("rst_bounce", bus.bounce, 0);
    check("rst_tick", bus.frame_tick, 0);
    check("rst_flash", bus.corner_flash, 0);
    check("rst_c_left", bus_c.logo_left, 511);
    check("rst_c_top", bus_c.logo_top, 1);

    // First frame, speed 0, with commit latency
    bus.vpos = 10'd480;
    @(negedge clk);
    bus.vpos = 10'd0;
    check("t1_tick", bus.frame_tick, 1);
    @(negedge clk);
    check("t1_tick_once", bus.frame_tick, 0);
    @(negedge clk);
    check("t1_hold_left", bus.logo_left, 200);
    @(negedge clk);
    check("t1_left", bus.logo_left, 201);
    check("t1_top", bus.logo_top, 199);
    check("t1_color", bus.color_index, 0);
    check("t1_bounce", bus.bounce, 0);
    check("corner_left", bus_c.logo_left, 512);
    check("corner_top", bus_c.logo_top, 0);
    check("corner_color", bus_c.color_index, 1);
    check("corner_bounce", bus_c.bounce, 1);
    check("corner_flash_0", bus_c.corner_flash, exp_flash(0));
    repeat (4) @(negedge clk);

    // Pause: ticks keep coming, motion freezes, corner flash counts down
    bus.pause = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      run_frame(t, b, bc);
      check($sformatf("pause%0d_tick", k), t, 1);
      check($sformatf("pause%0d_left", k), bus.logo_left, 201);
      check($sformatf("pause%0d_top", k), bus.logo_top, 199);
      check($sformatf("pause%0d_color", k), bus.color_index, 0);
      check($sformatf("pause%0d_flash", k), bus_c.corner_flash, exp_flash(k));
    end
    check("pause_c_left", bus_c.logo_left, 512);

    // Table of frames: speeds, a paused frame, speed change between frames
    for (int i = 0; i < 6; i++) begin
      bus.pause = vecs[i].pause;
      bus.speed = vecs[i].speed;
      run_frame(t, b, bc);
      check($sformatf("vec%0d_tick", i), t, 1);
      check($sformatf("vec%0d_left", i), bus.logo_left, vecs[i].left);
      check($sformatf("vec%0d_top", i), bus.logo_top, vecs[i].top);
      check($sformatf("vec%0d_color", i), bus.color_index, vecs[i].color);
      check($sformatf("vec%0d_bounce", i), b, vecs[i].bounces);
      if (i == 0) begin
        check("corner_next_left", bus_c.logo_left, 510);
        check("corner_next_top", bus_c.logo_top, 2);
        check("corner_next_color", bus_c.color_index, 1);
      end
    end

    // Speed change while the Y axis is being stepped applies to the next frame only
    bus.speed = 2'd0;
    @(negedge clk);
    bus.vpos = 10'd480;
    @(negedge clk);
    bus.vpos = 10'd0;
    @(negedge clk);
    bus.speed = 2'd3;
    repeat (6) @(negedge clk);
    check("spd_midy_left", bus.logo_left, 216);
    check("spd_midy_top", bus.logo_top, 184);
    run_frame(t, b, bc);
    check("spd_next_left", bus.logo_left, 220);
    check("spd_next_top", bus.logo_top, 180);

    // Reset while in STEP_Y
    @(negedge clk);
    bus.vpos = 10'd480;
    @(negedge clk);
    bus.vpos = 10'd0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_left", bus.logo_left, 200);
    check("rst_mid_top", bus.logo_top, 200);
    check("rst_mid_color", bus.color_index, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tot_b = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tot_b += int'(bus.bounce) + int'(bus.frame_tick);
    end
    check("rst_mid_nocommit_left", bus.logo_left, 200);
    check("rst_mid_nocommit_top", bus.logo_top, 200);
    check("rst_mid_quiet", tot_b, 0);

    // Run to the right edge: 2 frames at 1 px, 77 at 4 px (Y bounces off the top once)
    bus.speed = 2'd0;
    tot_b = 0;
    for (int i = 0; i < 2; i++) begin
      run_frame(t, b, bc);
      tot_b += b;
    end
    bus.speed = 2'd3;
    for (int i = 0; i < 77; i++) begin
      run_frame(t, b, bc);
      tot_b += b;
    end
    check("pre_left", bus.logo_left, 510);
    check("pre_top", bus.logo_top, 108);
    check("pre_color", bus.color_index, 1);
    check("pre_bounces", tot_b, 1);
    run_frame(t, b, bc);
    check("edge_left", bus.logo_left, 512);
    check("edge_top", bus.logo_top, 112);
    check("edge_color", bus.color_index, 2);
    check("edge_bounce", b, 1);
    run_frame(t, b, bc);
    check("after_edge_left", bus.logo_left, 508);
    check("after_edge_top", bus.logo_top, 116);
    check("after_edge_color", bus.color_index, 2);
    check("after_edge_bounce", b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
